// File: rtl/line_dma_writer_pkg.sv
// Shared types and constants for the line-scanner DMA writer.
// Status layout is {words_done[27:0], aborted, err, done, busy}.
package line_dma_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_BURST,
    ST_DONE
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 16;
  localparam int unsigned WORD_SHIFT     = $clog2(BYTES_PER_WORD);
  localparam int unsigned WDONE_W        = 28;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_DONE      = 1;
  localparam int unsigned STAT_ERR       = 2;
  localparam int unsigned STAT_ABORTED   = 3;
  localparam int unsigned STAT_WDONE_LSB = 4;

  // A job is rejected when it is empty or not whole-word aligned at either end.
  function automatic logic start_invalid(input logic [31:0] adr, input logic [31:0] size);
    return (size == 32'd0) ||
           (size[WORD_SHIFT-1:0] != '0) ||
           (adr[WORD_SHIFT-1:0] != '0);
  endfunction

endpackage

// File: rtl/line_dma_writer_if.sv
// Stream (line FIFO side) and Avalon-MM burst write bundles used by the DMA writer.
// master drives the payload; slave returns ready / waitrequest.
interface line_dma_stream_if #(
  parameter int DATA_W = 128
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, valid, input ready);
  modport slave  (input data, valid, output ready);
endinterface

interface line_dma_avm_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 28,
  parameter int BCNT_W = 8
);
  logic [ADDR_W-1:0]   address;
  logic [BCNT_W-1:0]   burstcount;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                waitrequest;

  modport master (output address, burstcount, write, writedata, byteenable, read,
                  input waitrequest);
  modport slave  (input address, burstcount, write, writedata, byteenable, read,
                  output waitrequest);
endinterface

// File: rtl/line_dma_writer.sv
// Streams line-FIFO words into DDR as Avalon-MM write bursts; first write 2 cycles after start, 1 bubble per burst.
// Backpressure: waitrequest stalls the stream via s.ready; stream gaps drop avm.write mid-burst.
module line_dma_writer
  import line_dma_writer_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int ADDR_W    = 28,
  parameter int BURST_LEN = 8,
  parameter int BCNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ctrl_start,
  input  logic             ctrl_abort,
  input  logic             irq_clr,
  input  logic [31:0]      buf_adr,
  input  logic [31:0]      buf_size,
  line_dma_stream_if.slave s,
  line_dma_avm_if.master   avm,
  output logic [31:0]      status,
  output logic             irq
);

  state_t             state;
  logic [ADDR_W-1:0]  adr_q;
  logic [ADDR_W-1:0]  burst_adr_q;
  logic [WDONE_W-1:0] rem_q;
  logic [WDONE_W-1:0] words_done;
  logic [BCNT_W-1:0]  len_q;
  logic [BCNT_W-1:0]  beat_q;
  logic [BCNT_W-1:0]  len_n;
  logic               busy;
  logic               done;
  logic               err;
  logic               aborted;
  logic               abort_pend;
  logic               in_burst;
  logic               accept;
  logic               last_beat;

  assign len_n = (rem_q >= WDONE_W'(BURST_LEN)) ? BCNT_W'(BURST_LEN) : BCNT_W'(rem_q);

  // Once an abort is pending the burst is padded with zero beats and the stream is left untouched.
  assign in_burst       = (state == ST_BURST);
  assign avm.write      = in_burst & (s.valid | abort_pend);
  assign avm.writedata  = (in_burst & ~abort_pend) ? s.data : '0;
  assign avm.address    = burst_adr_q;
  assign avm.burstcount = len_q;
  assign avm.byteenable = '1;
  assign avm.read       = 1'b0;
  assign s.ready        = in_burst & ~abort_pend & ~avm.waitrequest;

  assign accept    = avm.write & ~avm.waitrequest;
  assign last_beat = accept & ((beat_q + BCNT_W'(1)) == len_q);

  assign status = {words_done, aborted, err, done, busy};
  assign irq    = done | err | aborted;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      adr_q       <= '0;
      burst_adr_q <= '0;
      rem_q       <= '0;
      words_done  <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      aborted     <= 1'b0;
      abort_pend  <= 1'b0;
    end else begin
      if (irq_clr) begin
        done    <= 1'b0;
        err     <= 1'b0;
        aborted <= 1'b0;
      end
      if (ctrl_abort && busy) begin
        abort_pend <= 1'b1;
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (ctrl_start) begin
            adr_q      <= buf_adr[ADDR_W+WORD_SHIFT-1:WORD_SHIFT];
            rem_q      <= buf_size[WDONE_W+WORD_SHIFT-1:WORD_SHIFT];
            words_done <= '0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            abort_pend <= 1'b0;
            if (start_invalid(buf_adr, buf_size)) begin
              err   <= 1'b1;
              state <= ST_DONE;
            end else begin
              err   <= 1'b0;
              busy  <= 1'b1;
              state <= ST_ARM;
            end
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_ARM: begin
          if (abort_pend || ctrl_abort) begin
            busy       <= 1'b0;
            aborted    <= 1'b1;
            abort_pend <= 1'b0;
            state      <= ST_DONE;
          end else begin
            len_q       <= len_n;
            burst_adr_q <= adr_q;
            beat_q      <= '0;
            state       <= ST_BURST;
          end
        end

        ST_BURST: begin
          if (accept) begin
            beat_q <= beat_q + BCNT_W'(1);
          end
          // Progress is committed per burst, so words_done never shows a partial burst.
          if (last_beat) begin
            adr_q      <= adr_q + ADDR_W'(len_q);
            rem_q      <= rem_q - WDONE_W'(len_q);
            words_done <= words_done + WDONE_W'(len_q);
            if (abort_pend || (rem_q == WDONE_W'(len_q))) begin
              busy       <= 1'b0;
              done       <= ~abort_pend;
              aborted    <= abort_pend;
              abort_pend <= 1'b0;
              state      <= ST_DONE;
            end else begin
              state <= ST_ARM;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
